traffic_light_fsm: RTL and testbench

- Main intersection controller: sequences NS/EW vehicle lights, services pedestrian requests and enters night mode.
- In night mode it asserts `blink_enable` toward `blink_generator` and drives both yellow lamps from the returned `blink_out`.
- It sits directly upstream of `blink_generator` and directly drives the board LED outputs.

---
 rtl/traffic_pkg.sv | 43 ++++
 rtl/phase_timer.sv | 39 +++
 rtl/traffic_light_fsm.sv | 171 +++++++++++++++++
 tb/tb_traffic_light_fsm.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Definitions shared by the intersection controller and its phase timer.
//   TIMER_W       : width of every phase down-counter
//   lightState_e  : controller state encoding, also exported on state_dbg
//   direction_e   : which direction gets green after a pedestrian walk
//   LAMP_*        : per-direction lamp vectors ordered {red, yellow, green}
//   ticksToLoad   : turns a phase length in cycles into the counter load value
// ---------------------------------------------------------------------------
package traffic_pkg;

   localparam int TIMER_W = 32;

   localparam logic [TIMER_W-1:0] TIMER_ONE = 1;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_1 = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_2 = 3'd5,
      PED_WALK  = 3'd6,
      NIGHT     = 3'd7
   } lightState_e;

   typedef enum logic {
      DIR_NS = 1'b0,
      DIR_EW = 1'b1
   } direction_e;

   localparam logic [2:0] LAMP_OFF    = 3'b000;
   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   // The counter reaches zero on the last cycle of a phase, so a phase of
   // N cycles is loaded with N-1. N is always at least 1.
   function automatic logic [TIMER_W-1:0] ticksToLoad(input int unsigned ticks);
      return ticks - 32'd1;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Loadable down-counter that flags the last cycle of a timed phase.
//   clk          : system clock
//   reset        : asynchronous, active-high; counter returns to RESET_VALUE
//   load_i       : load loadValue_i this cycle (takes priority over counting)
//   loadValue_i  : value loaded on phase entry (phase length - 1)
//   terminal_o   : high while the counter reads zero
// The counter holds at zero until reloaded, so an untimed state can simply
// ignore terminal_o.
// ---------------------------------------------------------------------------
module phase_timer
   import traffic_pkg::*;
#(
   parameter logic [TIMER_W-1:0] RESET_VALUE = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic [TIMER_W-1:0] loadValue_i,
   output logic               terminal_o
);

   logic [TIMER_W-1:0] count_q;

   // Reload on phase entry, otherwise count down and park at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= RESET_VALUE;
      end else if (load_i) begin
         count_q <= loadValue_i;
      end else if (count_q != '0) begin
         count_q <= count_q - TIMER_ONE;
      end
   end

   assign terminal_o = (count_q == '0);

endmodule

// File: rtl/traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// traffic_light_fsm
// Intersection controller: cycles the NS/EW lights, inserts a pedestrian walk
// phase at an all-red decision point and runs a blinking-yellow night mode.
//   clk, reset         : system clock, asynchronous active-high reset
//   night_mode         : level request for night operation
//   ped_req            : single-cycle pedestrian request pulse
//   blink_in           : blink square wave from blink_generator
//   blink_enable       : enables blink_generator (NIGHT only)
//   ns_red/yellow/green, ew_red/yellow/green : vehicle lamps
//   ped_walk           : walk lamp
//   state_dbg          : current state encoding
// Lamps are decoded combinationally from the state register, so they change
// in the same cycle as state_dbg.
// ---------------------------------------------------------------------------
module traffic_light_fsm
   import traffic_pkg::*;
#(
   parameter int unsigned GREEN_TICKS    = 500_000_000,
   parameter int unsigned YELLOW_TICKS   = 150_000_000,
   parameter int unsigned ALL_RED_TICKS  = 50_000_000,
   parameter int unsigned PED_WALK_TICKS = 400_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       night_mode,
   input  logic       ped_req,
   input  logic       blink_in,
   output logic       blink_enable,
   output logic       ns_red,
   output logic       ns_yellow,
   output logic       ns_green,
   output logic       ew_red,
   output logic       ew_yellow,
   output logic       ew_green,
   output logic       ped_walk,
   output logic [2:0] state_dbg
);

   localparam logic [TIMER_W-1:0] GREEN_LOAD   = ticksToLoad(GREEN_TICKS);
   localparam logic [TIMER_W-1:0] YELLOW_LOAD  = ticksToLoad(YELLOW_TICKS);
   localparam logic [TIMER_W-1:0] ALL_RED_LOAD = ticksToLoad(ALL_RED_TICKS);
   localparam logic [TIMER_W-1:0] PED_LOAD     = ticksToLoad(PED_WALK_TICKS);

   lightState_e        state_q, state_d;
   logic               pedPending_q, pedPending_d;
   direction_e         nextDir_q, nextDir_d;
   logic               pedSeen;
   logic               phaseDone;
   logic               timerLoad;
   logic [TIMER_W-1:0] timerLoadValue;
   logic [2:0]         nsLamp;
   logic [2:0]         ewLamp;

   phase_timer #(
      .RESET_VALUE (ALL_RED_LOAD)
   ) u_phaseTimer (
      .clk         (clk),
      .reset       (reset),
      .load_i      (timerLoad),
      .loadValue_i (timerLoadValue),
      .terminal_o  (phaseDone)
   );

   // Next-state logic. pedSeen folds in a request arriving on the decision
   // cycle itself so it is serviced immediately rather than waiting a lap.
   // Requests are ignored while walking or in night mode. Every all-red
   // decision clears the pending request, including the one that picks NIGHT.
   always_comb begin
      state_d      = state_q;
      nextDir_d    = nextDir_q;
      pedSeen      = pedPending_q | ped_req;
      pedPending_d = 1'b0;
      if ((state_q != PED_WALK) && (state_q != NIGHT)) begin
         pedPending_d = pedSeen;
      end
      case (state_q)
         NS_GREEN:  if (phaseDone) state_d = NS_YELLOW;
         NS_YELLOW: if (phaseDone) state_d = ALL_RED_1;
         EW_GREEN:  if (phaseDone) state_d = EW_YELLOW;
         EW_YELLOW: if (phaseDone) state_d = ALL_RED_2;
         ALL_RED_1: begin
            if (phaseDone) begin
               pedPending_d = 1'b0;
               if (night_mode) begin
                  state_d = NIGHT;
               end else if (pedSeen) begin
                  state_d   = PED_WALK;
                  nextDir_d = DIR_EW;
               end else begin
                  state_d = EW_GREEN;
               end
            end
         end
         ALL_RED_2: begin
            if (phaseDone) begin
               pedPending_d = 1'b0;
               if (night_mode) begin
                  state_d = NIGHT;
               end else if (pedSeen) begin
                  state_d   = PED_WALK;
                  nextDir_d = DIR_NS;
               end else begin
                  state_d = NS_GREEN;
               end
            end
         end
         PED_WALK: begin
            if (phaseDone) begin
               state_d = (nextDir_q == DIR_EW) ? EW_GREEN : NS_GREEN;
            end
         end
         NIGHT:     if (!night_mode) state_d = ALL_RED_2;
         default:   state_d = ALL_RED_2;
      endcase
   end

   // Every state change restarts the timer with the length of the new phase.
   // NIGHT is untimed, so its load value is irrelevant.
   always_comb begin
      timerLoad = (state_d != state_q);
      case (state_d)
         NS_GREEN, EW_GREEN:   timerLoadValue = GREEN_LOAD;
         NS_YELLOW, EW_YELLOW: timerLoadValue = YELLOW_LOAD;
         ALL_RED_1, ALL_RED_2: timerLoadValue = ALL_RED_LOAD;
         PED_WALK:             timerLoadValue = PED_LOAD;
         default:              timerLoadValue = '0;
      endcase
   end

   // Reset lands in ALL_RED_2 so the first green after power-up is NS,
   // preceded by a full clearance interval.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ALL_RED_2;
         pedPending_q <= 1'b0;
         nextDir_q    <= DIR_NS;
      end else begin
         state_q      <= state_d;
         pedPending_q <= pedPending_d;
         nextDir_q    <= nextDir_d;
      end
   end

   // Moore output decode. Both directions default to red; in NIGHT the reds
   // go dark and both yellows follow the blink generator.
   always_comb begin
      nsLamp       = LAMP_RED;
      ewLamp       = LAMP_RED;
      ped_walk     = 1'b0;
      blink_enable = 1'b0;
      case (state_q)
         NS_GREEN:  nsLamp = LAMP_GREEN;
         NS_YELLOW: nsLamp = LAMP_YELLOW;
         EW_GREEN:  ewLamp = LAMP_GREEN;
         EW_YELLOW: ewLamp = LAMP_YELLOW;
         PED_WALK:  ped_walk = 1'b1;
         NIGHT: begin
            nsLamp       = blink_in ? LAMP_YELLOW : LAMP_OFF;
            ewLamp       = blink_in ? LAMP_YELLOW : LAMP_OFF;
            blink_enable = 1'b1;
         end
         default: ;
      endcase
   end

   assign {ns_red, ns_yellow, ns_green} = nsLamp;
   assign {ew_red, ew_yellow, ew_green} = ewLamp;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_fsm
// Self-checking bench for traffic_light_fsm with short phase lengths.
// A directed run-length table walks through the scenarios of interest, then
// randomized traffic is compared against a behavioural model of the rules.
// ---------------------------------------------------------------------------
module tb_traffic_light_fsm;

   localparam int GT  = 8;
   localparam int YT  = 3;
   localparam int ART = 2;
   localparam int PT  = 5;

   logic       clk = 1'b0;
   logic       reset;
   logic       night_mode;
   logic       ped_req;
   logic       blink_in;
   logic       blink_enable;
   logic       ns_red, ns_yellow, ns_green;
   logic       ew_red, ew_yellow, ew_green;
   logic       ped_walk;
   logic [2:0] state_dbg;
   logic [7:0] lampsAct;

   int checks = 0;
   int errors = 0;

   traffic_light_fsm #(
      .GREEN_TICKS    (GT),
      .YELLOW_TICKS   (YT),
      .ALL_RED_TICKS  (ART),
      .PED_WALK_TICKS (PT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .night_mode   (night_mode),
      .ped_req      (ped_req),
      .blink_in     (blink_in),
      .blink_enable (blink_enable),
      .ns_red       (ns_red),
      .ns_yellow    (ns_yellow),
      .ns_green     (ns_green),
      .ew_red       (ew_red),
      .ew_yellow    (ew_yellow),
      .ew_green     (ew_green),
      .ped_walk     (ped_walk),
      .state_dbg    (state_dbg)
   );

   always #5 clk = ~clk;

   assign lampsAct = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk, blink_enable};

   // Reference model: current phase number, cycles spent in it, a pending
   // walk request and the direction to resume after a walk.
   int mPhase;
   int mElapsed;
   bit mPending;
   bit mResumeEw;

   function automatic int phaseLen(input int p);
      case (p)
         0, 3:    return GT;
         1, 4:    return YT;
         2, 5:    return ART;
         6:       return PT;
         default: return 0;
      endcase
   endfunction

   function automatic logic [7:0] expLamps(input int p, input bit blink);
      bit nsR, nsY, nsG, ewR, ewY, ewG, walk, ben;
      nsR  = p inside {2, 3, 4, 5, 6};
      ewR  = p inside {0, 1, 2, 5, 6};
      nsG  = (p == 0);
      ewG  = (p == 3);
      nsY  = (p == 1) || (p == 7 && blink);
      ewY  = (p == 4) || (p == 7 && blink);
      walk = (p == 6);
      ben  = (p == 7);
      return {nsR, nsY, nsG, ewR, ewY, ewG, walk, ben};
   endfunction

   task automatic modelReset();
      mPhase    = 5;
      mElapsed  = 0;
      mPending  = 1'b0;
      mResumeEw = 1'b0;
   endtask

   task automatic enterPhase(input int p);
      mPhase   = p;
      mElapsed = 0;
   endtask

   // One clock edge of the intersection rules.
   task automatic modelStep(input bit night, input bit ped);
      bit lastCycle;
      bit afterNs;
      if (mPhase == 7) begin
         if (!night) enterPhase(5);
         return;
      end
      if (ped && mPhase != 6) mPending = 1'b1;
      lastCycle = (mElapsed + 1 >= phaseLen(mPhase));
      if (!lastCycle) begin
         mElapsed++;
         return;
      end
      if (mPhase == 2 || mPhase == 5) begin
         afterNs = (mPhase == 2);
         if (night) begin
            mPending = 1'b0;
            enterPhase(7);
         end else if (mPending) begin
            mPending  = 1'b0;
            mResumeEw = afterNs;
            enterPhase(6);
         end else begin
            enterPhase(afterNs ? 3 : 0);
         end
      end else if (mPhase == 6) begin
         enterPhase(mResumeEw ? 3 : 0);
      end else begin
         enterPhase(mPhase + 1);
      end
   endtask

   task automatic applyStimulus(input bit n, input bit p, input bit b);
      night_mode = n;
      ped_req    = p;
      blink_in   = b;
      @(posedge clk);
      modelStep(n, p);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      checks++;
      if (state_dbg !== 3'(mPhase)) begin
         errors++;
         $display("[TB] FAIL %s state: got %0d want %0d at %0t", tag, state_dbg, mPhase, $time);
      end
      checks++;
      if (lampsAct !== expLamps(mPhase, blink_in)) begin
         errors++;
         $display("[TB] FAIL %s lamps: got %b want %b at %0t", tag, lampsAct, expLamps(mPhase, blink_in), $time);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checks++;
      if ({state_dbg, lampsAct} !== {3'd5, 8'b100_100_0_0}) begin
         errors++;
         $display("[TB] FAIL %s reset values: got state %0d lamps %b want state 5 lamps 10010000", tag, state_dbg, lampsAct);
      end
   endtask

   // Asynchronous reset asserted mid-cycle, released on the next falling edge.
   task automatic midReset(input string tag);
      night_mode = 1'b0;
      ped_req    = 1'b0;
      reset      = 1'b1;
      modelReset();
      #1;
      checkResetValues(tag);
      checkOutput(tag);
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      bit night;
      bit ped;
      bit blink;
      int expState;
      int cycles;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input bit n, input bit p, input bit b, input int s, input int c);
      vec_t v;
      v.night    = n;
      v.ped      = p;
      v.blink    = b;
      v.expState = s;
      v.cycles   = c;
      vecs.push_back(v);
   endtask

   initial begin
      bit nightLvl;

      reset      = 1'b1;
      night_mode = 1'b0;
      ped_req    = 1'b0;
      blink_in   = 1'b0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkResetValues("por");
      checkOutput("por");
      @(negedge clk);
      reset = 1'b0;

      // Each record: inputs held for 'cycles' edges, state expected after each.
      // Normal period from reset release.
      addVec(0,0,0, 5,1); addVec(0,0,0, 0,8); addVec(0,0,1, 1,3); addVec(0,0,0, 2,2);
      addVec(0,0,1, 3,8); addVec(0,0,0, 4,3); addVec(0,0,1, 5,2); addVec(0,0,0, 0,1);
      // Pedestrian request in NS_GREEN, second request inside the walk, and
      // one on the walk-to-green transition, neither producing another walk.
      addVec(0,1,0, 0,1); addVec(0,0,0, 0,6); addVec(0,0,1, 1,3); addVec(0,0,0, 2,2);
      addVec(0,0,0, 6,2); addVec(0,1,1, 6,1); addVec(0,0,0, 6,2); addVec(0,1,0, 3,1);
      addVec(0,0,1, 3,7); addVec(0,0,0, 4,3); addVec(0,0,0, 5,2); addVec(0,0,0, 0,1);
      // Night mode raised mid EW_GREEN, held, then dropped.
      addVec(0,0,0, 0,7); addVec(0,0,1, 1,3); addVec(0,0,0, 2,2); addVec(0,0,0, 3,4);
      addVec(1,0,0, 3,4); addVec(1,0,1, 4,3); addVec(1,0,0, 5,2); addVec(1,0,1, 7,2);
      addVec(1,0,0, 7,2); addVec(1,0,1, 7,1); addVec(0,0,1, 5,2); addVec(0,0,0, 0,1);
      // Night and pedestrian together: night wins, the request is lost.
      addVec(0,0,0, 0,7); addVec(0,0,0, 1,3); addVec(0,0,0, 2,2); addVec(0,0,0, 3,8);
      addVec(0,0,0, 4,2); addVec(1,1,0, 4,1); addVec(1,0,0, 5,2); addVec(1,0,1, 7,3);
      addVec(0,0,0, 5,2); addVec(0,0,0, 0,8); addVec(0,0,0, 1,3); addVec(0,0,0, 2,2);
      addVec(0,0,0, 3,1);
      // Request on the ALL_RED_2 terminal cycle is serviced; stop mid walk.
      addVec(0,0,0, 3,7); addVec(0,0,0, 4,3); addVec(0,0,0, 5,2); addVec(0,1,0, 6,1);
      addVec(0,0,0, 6,2);

      foreach (vecs[i]) begin
         for (int c = 0; c < vecs[i].cycles; c++) begin
            applyStimulus(vecs[i].night, vecs[i].ped, vecs[i].blink ^ c[0]);
            checks++;
            if (state_dbg !== 3'(vecs[i].expState)) begin
               errors++;
               $display("[TB] FAIL table[%0d] state: got %0d want %0d", i, state_dbg, vecs[i].expState);
            end
            checkOutput($sformatf("table[%0d]", i));
         end
      end

      midReset("ped_walk_reset");
      applyStimulus(0, 0, 1);
      checkOutput("after_reset");

      nightLvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 79) == 0) nightLvl = !nightLvl;
         if ($urandom_range(0, 599) == 0) begin
            midReset("random_reset");
         end else begin
            applyStimulus(nightLvl, $urandom_range(0, 14) == 0, 1'($urandom_range(0, 1)));
            checkOutput("random");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
